sobel_window_gen: RTL and testbench

Streaming 3x3 window generator that sits directly upstream of the Sobel gradient stage. It accepts one raster-order pixel per handshake and buffers the two previous image rows. For every interior pixel it presents the full 3x3 neighbourhood P0..P8 (row-major, P4 = centre) so the gradient stage never computes memory indices itself.

---
 rtl/sobel_pkg.sv | 30 +++
 rtl/sobel_line_buf.sv | 33 +++
 rtl/sobel_window_gen.sv | 170 +++++++++++++++++
 tb/tb_sobel_window_gen.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared constants and window packing helper for the Sobel pipeline
//
// Purpose : image geometry defaults, 3x3 window tap indices (row-major,
//           P4 = centre) and the tap-to-bit-slice mapping used by both the
//           window generator and the gradient stage.
// Ports   : none (package).
package sobel_pkg;

    localparam int SOBEL_IMG_W = 64;
    localparam int SOBEL_IMG_H = 64;
    localparam int SOBEL_PIX_W = 8;

    // Window taps, row-major: P0..P2 oldest row, P6..P8 newest row.
    localparam int TAP_P0 = 0;
    localparam int TAP_P1 = 1;
    localparam int TAP_P2 = 2;
    localparam int TAP_P3 = 3;
    localparam int TAP_P4 = 4;
    localparam int TAP_P5 = 5;
    localparam int TAP_P6 = 6;
    localparam int TAP_P7 = 7;
    localparam int TAP_P8 = 8;
    localparam int TAP_COUNT = 9;

    // Tap k occupies win_data[tap_lsb(k) +: pix_w].
    function automatic int tap_lsb(input int k, input int pix_w);
        return pix_w * k;
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// rtl/sobel_line_buf.sv - single-address read-before-write line buffer
//
// Purpose : DEPTH x WIDTH memory holding one image row. The read port is
//           asynchronous on the same address as the write, so a cycle that
//           writes still returns the previous contents.
// Ports   : clk   - clock
//           we    - write enable
//           addr  - shared read/write address (column)
//           wdata - data written on we
//           rdata - current contents at addr (pre-write)
module sobel_line_buf #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    // Not reset: rows are only consumed after being fully rewritten.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/sobel_window_gen.sv
// rtl/sobel_window_gen.sv - streaming 3x3 window generator feeding the Sobel stage
//
// Purpose : accepts raster-order pixels, buffers the two previous rows and
//           emits the 3x3 neighbourhood of every interior pixel, one cycle
//           after the pixel completing the window is accepted.
// Ports   : clk, rst            - clock, asynchronous active-high reset
//           in_valid/in_ready   - pixel handshake, in_pixel raster order
//           win_valid/win_ready - window handshake, win_data = P0..P8
//           win_row/win_col     - window centre (only with SOBEL_WIN_COORD_EN)
//           frame_done          - pulse, last pixel of a frame accepted
// Config  : SOBEL_WIN_COORD_EN adds the win_row/win_col ports and registers.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W = SOBEL_IMG_W,
    parameter int IMG_H = SOBEL_IMG_H,
    parameter int PIX_W = SOBEL_PIX_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PIX_W-1:0]         in_pixel,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic [9*PIX_W-1:0]       win_data,
`ifdef SOBEL_WIN_COORD_EN
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col,
`endif
    output logic                     frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]      c_q, c_d;
    logic [RW-1:0]      r_q, r_d;
    // Two most recent window columns; [row][0] is column c-2, [row][1] is c-1.
    logic [PIX_W-1:0]   sr_q [3][2];
    logic [PIX_W-1:0]   sr_d [3][2];
    logic [PIX_W-1:0]   col_new [3];
    logic [PIX_W-1:0]   taps [TAP_COUNT];
    logic [9*PIX_W-1:0] win_pack;
    logic [9*PIX_W-1:0] win_data_q;
    logic               win_valid_q, win_valid_d;
    logic               frame_done_q;
    logic [PIX_W-1:0]   lb0_rd, lb1_rd;
    logic               accept, emit, last_col, last_row;

    assign in_ready = !win_valid_q || win_ready;
    assign accept   = in_valid && in_ready;
    assign last_col = (c_q == CW'(IMG_W - 1));
    assign last_row = (r_q == RW'(IMG_H - 1));
    // Suppressing c < 2 hides stale columns from the previous row, and
    // r < 2 hides rows from the previous frame.
    assign emit     = accept && (r_q >= RW'(2)) && (c_q >= CW'(2));

    // LB0 holds row r-2, LB1 row r-1; on accept the older row shifts down.
    sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk   (clk),
        .we    (accept),
        .addr  (c_q),
        .wdata (lb1_rd),
        .rdata (lb0_rd)
    );

    sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (c_q),
        .wdata (in_pixel),
        .rdata (lb1_rd)
    );

    always_comb begin
        col_new[0] = lb0_rd;
        col_new[1] = lb1_rd;
        col_new[2] = in_pixel;
    end

    always_comb begin
        taps[TAP_P0] = sr_q[0][0];
        taps[TAP_P1] = sr_q[0][1];
        taps[TAP_P2] = col_new[0];
        taps[TAP_P3] = sr_q[1][0];
        taps[TAP_P4] = sr_q[1][1];
        taps[TAP_P5] = col_new[1];
        taps[TAP_P6] = sr_q[2][0];
        taps[TAP_P7] = sr_q[2][1];
        taps[TAP_P8] = col_new[2];
        win_pack = '0;
        for (int k = 0; k < TAP_COUNT; k++) begin
            win_pack[tap_lsb(k, PIX_W) +: PIX_W] = taps[k];
        end
    end

    always_comb begin
        c_d  = c_q;
        r_d  = r_q;
        sr_d = sr_q;
        if (accept) begin
            if (last_col) begin
                c_d = '0;
                r_d = last_row ? '0 : r_q + RW'(1);
            end else begin
                c_d = c_q + CW'(1);
            end
            for (int row = 0; row < 3; row++) begin
                sr_d[row][0] = sr_q[row][1];
                sr_d[row][1] = col_new[row];
            end
        end
    end

    always_comb begin
        win_valid_d = win_valid_q;
        if (emit) begin
            win_valid_d = 1'b1;
        end else if (win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q          <= '0;
            r_q          <= '0;
            win_valid_q  <= 1'b0;
            win_data_q   <= '0;
            frame_done_q <= 1'b0;
            for (int row = 0; row < 3; row++) begin
                sr_q[row][0] <= '0;
                sr_q[row][1] <= '0;
            end
        end else begin
            c_q          <= c_d;
            r_q          <= r_d;
            sr_q         <= sr_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= accept && last_col && last_row;
            if (emit) begin
                win_data_q <= win_pack;
            end
        end
    end

`ifdef SOBEL_WIN_COORD_EN
    logic [RW-1:0] win_row_q;
    logic [CW-1:0] win_col_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_row_q <= '0;
            win_col_q <= '0;
        end else if (emit) begin
            win_row_q <= r_q - RW'(1);
            win_col_q <= c_q - CW'(1);
        end
    end

    assign win_row = win_row_q;
    assign win_col = win_col_q;
`endif

    assign win_valid  = win_valid_q;
    assign win_data   = win_data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// tb/tb_sobel_window_gen.sv - self-checking bench for sobel_window_gen
module tb_sobel_window_gen;

    localparam int W  = 64;
    localparam int H  = 64;
    localparam int PW = 8;

    typedef struct {
        logic [9*PW-1:0] data;
        int              frame;
        int              row;
        int              col;
    } sb_t;

    typedef struct {
        int          tap;
        logic [7:0]  exp;
    } tap_vec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [PW-1:0]   in_pixel = '0;
    logic            win_valid;
    logic            win_ready = 1'b1;
    logic [9*PW-1:0] win_data;
    logic            frame_done;
`ifdef SOBEL_WIN_COORD_EN
    logic [5:0]      win_row;
    logic [5:0]      win_col;
`endif

    always #5 clk = ~clk;

    sobel_window_gen dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_data   (win_data),
`ifdef SOBEL_WIN_COORD_EN
        .win_row    (win_row),
        .win_col    (win_col),
`endif
        .frame_done (frame_done)
    );

    int         n_vec = 0;
    int         n_bad = 0;
    int         mr = 0, mc = 0;
    int         cur_frame = 0;
    int         n_acc = 0;
    logic       exp_wv = 1'b0;
    logic       exp_fd = 1'b0;
    logic       last_acc = 1'b0;
    logic [7:0] img [H][W];
    sb_t        q[$];
    int         win_cnt [8];
    int         fd_total = 0;
    logic       first_armed = 1'b0;
    logic       first_capture = 1'b0;
    logic [9*PW-1:0] first_win = '0;

    task automatic check(input string name, input logic [9*PW-1:0] act, input logic [9*PW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pix_of(input int kind, input int r, input int c);
        logic [7:0] base;
        base = 8'((64 * r + c) % 256);
        case (kind)
            1:       return ~base;
            2:       return base + 8'd37;
            default: return base;
        endcase
    endfunction

    // One clock: drive inputs after the falling edge, check, then advance the model
    // for whatever the next rising edge will do.
    task automatic cycle(input logic v, input logic [7:0] p, input logic wr);
        sb_t e;
        logic acc;
        @(negedge clk);
        in_valid  = v;
        in_pixel  = p;
        win_ready = wr;
        #1;
        check("win_valid", {71'd0, win_valid}, {71'd0, exp_wv});
        check("in_ready", {71'd0, in_ready}, {71'd0, (!exp_wv || wr)});
        check("frame_done", {71'd0, frame_done}, {71'd0, exp_fd});
        if (frame_done) fd_total++;
        if (exp_wv && first_armed) begin
            check("first_win_accepts", 72'(n_acc), 72'd131);
            first_armed = 1'b0;
        end
        if (exp_wv) begin
            check(wr ? "win_data" : "win_hold", win_data, q[0].data);
`ifdef SOBEL_WIN_COORD_EN
            check("win_row", {66'd0, win_row}, 72'(q[0].row - 1));
            check("win_col", {66'd0, win_col}, 72'(q[0].col - 1));
`endif
            if (wr) begin
                e = q.pop_front();
                win_cnt[e.frame]++;
                if (first_capture) begin
                    first_win = win_data;
                    first_capture = 1'b0;
                end
            end
        end
        acc = v && (!exp_wv || wr);
        last_acc = acc;
        exp_fd = 1'b0;
        if (wr) exp_wv = 1'b0;
        if (acc) begin
            img[mr][mc] = p;
            n_acc++;
            if (mr >= 2 && mc >= 2) begin
                e.data  = '0;
                for (int k = 0; k < 9; k++)
                    e.data[PW*k +: PW] = img[mr - 2 + k / 3][mc - 2 + k % 3];
                e.frame = cur_frame;
                e.row   = mr;
                e.col   = mc;
                q.push_back(e);
                exp_wv  = 1'b1;
            end
            if (mr == H - 1 && mc == W - 1) exp_fd = 1'b1;
            if (mc == W - 1) begin
                mc = 0;
                mr = (mr == H - 1) ? 0 : mr + 1;
            end else begin
                mc++;
            end
        end
    endtask

    // mode 0: no stalls, 1: one forced 5-cycle stall, 2: random valid/ready.
    task automatic run_frame(input int frame, input int kind, input int mode, input int stop_after);
        int   i;
        logic stalled;
        logic v, wr;
        i = 0;
        stalled = 1'b0;
        cur_frame = frame;
        n_acc = 0;
        while (i < stop_after) begin
            if (mode == 1 && i == 301 && !stalled) begin
                repeat (5) cycle(1'b1, pix_of(kind, i / W, i % W), 1'b0);
                stalled = 1'b1;
            end
            v  = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            wr = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            cycle(v, pix_of(kind, i / W, i % W), wr);
            if (last_acc) i++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_win_valid", {71'd0, win_valid}, 72'd0);
        check("rst_frame_done", {71'd0, frame_done}, 72'd0);
        check("rst_win_data", win_data, 72'd0);
        check("rst_in_ready", {71'd0, in_ready}, 72'd1);
        @(negedge clk);
        #1 rst = 1'b0;
        mr = 0;
        mc = 0;
        exp_wv = 1'b0;
        exp_fd = 1'b0;
        n_acc = 0;
        q.delete();
    endtask

    tap_vec_t tap_tbl [9];

    initial begin
        tap_tbl[0] = '{0, 8'd0};
        tap_tbl[1] = '{1, 8'd1};
        tap_tbl[2] = '{2, 8'd2};
        tap_tbl[3] = '{3, 8'd64};
        tap_tbl[4] = '{4, 8'd65};
        tap_tbl[5] = '{5, 8'd66};
        tap_tbl[6] = '{6, 8'd128};
        tap_tbl[7] = '{7, 8'd129};
        tap_tbl[8] = '{8, 8'd130};
        for (int f = 0; f < 8; f++) win_cnt[f] = 0;

        #1 rst = 1'b1;
        #1;
        check("init_win_valid", {71'd0, win_valid}, 72'd0);
        check("init_win_data", win_data, 72'd0);
        check("init_frame_done", {71'd0, frame_done}, 72'd0);
        check("init_in_ready", {71'd0, in_ready}, 72'd1);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        // Frame 1: ramp, no stalls; first window taps checked from the table.
        first_armed = 1'b1;
        first_capture = 1'b1;
        run_frame(1, 0, 0, W * H);

        // Frame 2 back-to-back: inverted ramp with one forced 5-cycle stall.
        run_frame(2, 1, 1, W * H);
        cycle(1'b0, 8'd0, 1'b1);
        cycle(1'b0, 8'd0, 1'b1);
        check("frame1_windows", 72'(win_cnt[1]), 72'd3844);
        check("frame2_windows", 72'(win_cnt[2]), 72'd3844);
        for (int t = 0; t < 9; t++)
            check($sformatf("first_win_P%0d", tap_tbl[t].tap),
                  {64'd0, first_win[PW*tap_tbl[t].tap +: PW]}, {64'd0, tap_tbl[t].exp});

        // Frame 3: abandoned by a reset after 1000 accepts.
        run_frame(3, 2, 2, 1000);
        do_reset();

        // Frame 4: fresh frame after reset, random handshakes.
        first_armed = 1'b1;
        run_frame(4, 2, 2, W * H);
        cycle(1'b0, 8'd0, 1'b1);
        cycle(1'b0, 8'd0, 1'b1);
        check("frame4_windows", 72'(win_cnt[4]), 72'd3844);
        check("frame_done_total", 72'(fd_total), 72'd3);
        check("sb_drained", 72'(q.size()), 72'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
